plc_ton_timer: RTL and testbench
================================

// Module: plc_ton_timer
// PURPOSE
//  Ladder-logic timer primitive (TON, or RTO when RETENTIVE=1) that feeds the generated rung
//  logic. Consumes the DownClock tick as time base; produces the EN/TT/DN status bits and ACC
//  value that rungs read (e.g. tpvac.TT, tvac1.DN). One instance per timer tag.
// PARAMETERS
//  ACC_W      32  width of preset and accumulator
//  TICK_DIV   1   ticks per ACC increment (time-base prescale, >=1)
//  RETENTIVE  0   0 = TON (ACC clears on rung false); 1 = RTO (ACC holds, cleared by res only)
// PORTS
//  clk     in   1      system clock (CLOCK_50 domain)
//  rst     in   1      asynchronous, active-high reset
//  tick    in   1      single-cycle time-base pulse from DownClock
//  rung    in   1      rung condition driving the timer instruction
//  res     in   1      RES instruction: clear ACC/DN/prescaler (level, synchronous)
//  pre     in   ACC_W  preset (.PRE); sampled every cycle
//  en      out  1      .EN status
//  tt      out  1      .TT status (timing)
//  dn      out  1      .DN status (done)
//  acc     out  ACC_W  .ACC accumulator
// BEHAVIOUR
//  - All outputs registered. Reset: en=0, tt=0, dn=0, acc=0, prescaler=0, state=IDLE.
//  - States: IDLE (acc=0, not timing), TIMING, DONE, HOLD (RETENTIVE=1 only; rung false, acc kept).
//  - en = rung delayed one clk. tt = (state==TIMING). dn = (state==DONE) or (HOLD with acc>=pre).
//  - IDLE: rung=1 -> TIMING next cycle (pre==0 -> DONE directly, dn=1 one cycle after rung rises).
//  - TIMING: each tick with rung=1 advances prescaler; when prescaler reaches TICK_DIV-1 it wraps
//    to 0 and acc increments by 1. When acc+1 (or acc) >= pre -> DONE; acc saturates at pre.
//  - DONE: acc holds at pre, no further increment. rung=1 stays DONE.
//  - rung falls, RETENTIVE=0: next cycle acc=0, prescaler=0, tt=0, dn=0, state IDLE.
//  - rung falls, RETENTIVE=1: acc and prescaler held, tt=0, state HOLD (dn held if done);
//    rung rises again -> resume TIMING (or DONE if acc>=pre) from held acc.
//  - pre lowered mid-timing to <= acc: DONE next cycle, acc clamped to new pre.
//    pre raised above acc while DONE: back to TIMING next cycle, dn=0, acc continues.
//  - Latency: rung rise to first acc increment = TICK_DIV ticks; dn asserts the clk after the
//    tick that makes acc==pre.
//  - res=1: acc=0, prescaler=0, dn=0 next cycle; state IDLE if rung=0, TIMING if rung=1
//    (pre==0 -> DONE). res overrides a same-cycle tick and any rung change.
//  - tick while rung=0 or in IDLE/DONE/HOLD: ignored. Multi-cycle tick high counts once
//    per cycle high (DownClock guarantees 1-cycle pulses).
//  - Arithmetic unsigned ACC_W; acc never wraps (saturate at pre, pre <= 2^ACC_W-1).
//  - Async rst mid-operation: immediate return to reset values regardless of rung/tick.
// TESTING
//  1 TON, TICK_DIV=1, pre=5, rung=1, 6 ticks -> tt=1 for ticks 0-4, acc 1..5, dn=1 after 5th
//    tick, tt=0; 6th tick acc stays 5.
//  2 TON pre=5, rung dropped at acc=3 -> next clk acc=0, tt=0, dn=0; rung rise restarts from 0.
//  3 RTO pre=5, rung dropped at acc=3, 4 ticks while low -> acc=3 held; rung high, 2 ticks ->
//    acc=5, dn=1; res pulse -> acc=0, dn=0.
//  4 pre=0, rung rise -> dn=1 one clk later, acc=0, tt never 1; TICK_DIV=4, pre=2 -> acc=1 on
//    4th tick, dn after 8th tick.
//  5 pre lowered 10->2 at acc=4 -> next clk dn=1, acc=2; pre raised back to 10 -> dn=0, tt=1.
//  6 rst asserted mid-timing at acc=7 (async, between clk edges) -> all outputs 0 immediately;
//    res+tick same cycle -> acc=0, no increment.

Source files
------------

// File: rtl/plc_ton_timer_if.sv
// Timer tag bus: rung-side controls in, EN/TT/DN/ACC status out.
// The master drives the rung; the slave is the timer instance.
interface plc_ton_timer_if #(
    parameter int ACC_W = 32
);
    logic             tick;
    logic             rung;
    logic             res;
    logic [ACC_W-1:0] pre;
    logic             en;
    logic             tt;
    logic             dn;
    logic [ACC_W-1:0] acc;

    modport master (
        output tick, rung, res, pre,
        input  en, tt, dn, acc
    );

    modport slave (
        input  tick, rung, res, pre,
        output en, tt, dn, acc
    );
endinterface

// File: rtl/plc_ton_timer.sv
// TON / RTO ladder timer primitive with tick prescaler.
// All status bits and ACC are registered.
module plc_ton_timer #(
    parameter int ACC_W     = 32,
    parameter int TICK_DIV  = 1,
    parameter bit RETENTIVE = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    plc_ton_timer_if.slave  bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PSC_TOP = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        TIMING,
        DONE,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [PW-1:0]    psc_q, psc_d;
    logic             en_q, en_d;
    logic             dn_q, dn_d;
    logic             tt_q, tt_d;
    logic [ACC_W-1:0] acc_inc;
    logic             pre_zero;

    assign acc_inc  = acc_q + 1'b1;
    assign pre_zero = (bus.pre == '0);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        psc_d   = psc_q;
        en_d    = bus.rung;

        if (bus.res) begin
            acc_d   = '0;
            psc_d   = '0;
            if (!bus.rung)
                state_d = IDLE;
            else
                state_d = pre_zero ? DONE : TIMING;
        end else if (!bus.rung) begin
            if (!RETENTIVE) begin
                state_d = IDLE;
                acc_d   = '0;
                psc_d   = '0;
            end else if (state_q != IDLE) begin
                state_d = HOLD;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    acc_d   = '0;
                    psc_d   = '0;
                    state_d = pre_zero ? DONE : TIMING;
                end
                HOLD: begin
                    if (acc_q >= bus.pre) begin
                        state_d = DONE;
                        acc_d   = bus.pre;
                    end else begin
                        state_d = TIMING;
                    end
                end
                TIMING: begin
                    // Preset may have been lowered under the running count.
                    if (acc_q >= bus.pre) begin
                        state_d = DONE;
                        acc_d   = bus.pre;
                    end else if (bus.tick) begin
                        if (psc_q == PSC_TOP) begin
                            psc_d = '0;
                            acc_d = acc_inc;
                            if (acc_inc >= bus.pre)
                                state_d = DONE;
                        end else begin
                            psc_d = psc_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.pre > acc_q)
                        state_d = TIMING;
                    else
                        acc_d = bus.pre;
                end
                default: state_d = IDLE;
            endcase
        end

        tt_d = (state_d == TIMING);
        dn_d = (state_d == DONE) ||
               ((state_d == HOLD) && (acc_d >= bus.pre));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            psc_q   <= '0;
            en_q    <= 1'b0;
            tt_q    <= 1'b0;
            dn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            psc_q   <= psc_d;
            en_q    <= en_d;
            tt_q    <= tt_d;
            dn_q    <= dn_d;
        end
    end

    assign bus.en  = en_q;
    assign bus.tt  = tt_q;
    assign bus.dn  = dn_q;
    assign bus.acc = acc_q;
endmodule

// File: tb/tb_plc_ton_timer.sv
// Directed bench: TON/div1, RTO/div1 and TON/div4 timer instances.
// Shared clock and reset; each instance has its own bus.
module tb_plc_ton_timer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    plc_ton_timer_if #(.ACC_W(32)) ta ();
    plc_ton_timer_if #(.ACC_W(32)) tb ();
    plc_ton_timer_if #(.ACC_W(32)) tc ();

    plc_ton_timer #(.ACC_W(32), .TICK_DIV(1), .RETENTIVE(1'b0))
        u_ton (.clk(clk), .rst(rst), .bus(ta));
    plc_ton_timer #(.ACC_W(32), .TICK_DIV(1), .RETENTIVE(1'b1))
        u_rto (.clk(clk), .rst(rst), .bus(tb));
    plc_ton_timer #(.ACC_W(32), .TICK_DIV(4), .RETENTIVE(1'b0))
        u_div (.clk(clk), .rst(rst), .bus(tc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_a();
        ta.tick = 1'b1;
        step();
        ta.tick = 1'b0;
    endtask

    task automatic tick_b();
        tb.tick = 1'b1;
        step();
        tb.tick = 1'b0;
    endtask

    task automatic tick_c();
        tc.tick = 1'b1;
        step();
        tc.tick = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ta.tick = 0; ta.rung = 0; ta.res = 0; ta.pre = 0;
        tb.tick = 0; tb.rung = 0; tb.res = 0; tb.pre = 0;
        tc.tick = 0; tc.rung = 0; tc.res = 0; tc.pre = 0;
        rst = 1'b1;
        step();
        step();
        chk("rst_acc", ta.acc, 0);
        chk("rst_en", {31'b0, ta.en}, 0);
        chk("rst_tt", {31'b0, ta.tt}, 0);
        chk("rst_dn", {31'b0, ta.dn}, 0);
        chk("rst_rto_acc", tb.acc, 0);
        rst = 1'b0;
        step();

        // 1: TON count to preset and saturate
        ta.pre  = 5;
        ta.rung = 1'b1;
        step();
        chk("t1_en", {31'b0, ta.en}, 1);
        chk("t1_tt0", {31'b0, ta.tt}, 1);
        chk("t1_acc0", ta.acc, 0);
        for (int i = 1; i <= 5; i++) begin
            tick_a();
            chk("t1_acc", ta.acc, i);
            chk("t1_tt", {31'b0, ta.tt}, (i < 5) ? 1 : 0);
            chk("t1_dn", {31'b0, ta.dn}, (i == 5) ? 1 : 0);
        end
        tick_a();
        chk("t1_sat", ta.acc, 5);
        chk("t1_dn6", {31'b0, ta.dn}, 1);

        // 2: TON rung drop clears
        ta.rung = 1'b0;
        step();
        chk("t2_clr", ta.acc, 0);
        chk("t2_dn", {31'b0, ta.dn}, 0);
        ta.rung = 1'b1;
        step();
        for (int i = 0; i < 3; i++) tick_a();
        chk("t2_acc3", ta.acc, 3);
        ta.rung = 1'b0;
        step();
        chk("t2_drop_acc", ta.acc, 0);
        chk("t2_drop_tt", {31'b0, ta.tt}, 0);
        chk("t2_drop_dn", {31'b0, ta.dn}, 0);
        chk("t2_drop_en", {31'b0, ta.en}, 0);
        ta.rung = 1'b1;
        step();
        chk("t2_rest_tt", {31'b0, ta.tt}, 1);
        tick_a();
        chk("t2_rest_acc", ta.acc, 1);

        // 3: RTO hold, resume, reset
        tb.pre  = 5;
        tb.rung = 1'b1;
        step();
        for (int i = 0; i < 3; i++) tick_b();
        chk("t3_acc3", tb.acc, 3);
        tb.rung = 1'b0;
        step();
        chk("t3_hold_acc", tb.acc, 3);
        chk("t3_hold_tt", {31'b0, tb.tt}, 0);
        chk("t3_hold_dn", {31'b0, tb.dn}, 0);
        for (int i = 0; i < 4; i++) tick_b();
        chk("t3_low_ticks", tb.acc, 3);
        tb.rung = 1'b1;
        step();
        chk("t3_resume_tt", {31'b0, tb.tt}, 1);
        chk("t3_resume_acc", tb.acc, 3);
        tick_b();
        tick_b();
        chk("t3_acc5", tb.acc, 5);
        chk("t3_dn", {31'b0, tb.dn}, 1);
        tb.res = 1'b1;
        step();
        tb.res = 1'b0;
        chk("t3_res_acc", tb.acc, 0);
        chk("t3_res_dn", {31'b0, tb.dn}, 0);
        chk("t3_res_tt", {31'b0, tb.tt}, 1);

        // 4a: zero preset is done one clk after rung rise
        ta.rung = 1'b0;
        step();
        ta.pre  = 0;
        ta.rung = 1'b1;
        step();
        chk("t4_dn", {31'b0, ta.dn}, 1);
        chk("t4_acc", ta.acc, 0);
        chk("t4_tt", {31'b0, ta.tt}, 0);
        tick_a();
        chk("t4_tt2", {31'b0, ta.tt}, 0);

        // 4b: prescale by 4
        tc.pre  = 2;
        tc.rung = 1'b1;
        step();
        for (int i = 1; i <= 8; i++) begin
            tick_c();
            chk("t4_div_acc", tc.acc, i / 4);
            chk("t4_div_dn", {31'b0, tc.dn}, (i == 8) ? 1 : 0);
        end

        // 5: preset lowered then raised
        ta.rung = 1'b0;
        step();
        ta.pre  = 10;
        ta.rung = 1'b1;
        step();
        for (int i = 0; i < 4; i++) tick_a();
        chk("t5_acc4", ta.acc, 4);
        ta.pre = 2;
        step();
        chk("t5_lo_dn", {31'b0, ta.dn}, 1);
        chk("t5_lo_acc", ta.acc, 2);
        ta.pre = 10;
        step();
        chk("t5_hi_dn", {31'b0, ta.dn}, 0);
        chk("t5_hi_tt", {31'b0, ta.tt}, 1);
        tick_a();
        chk("t5_hi_acc", ta.acc, 3);

        // 6: async reset mid-timing, then res beats tick
        ta.rung = 1'b0;
        step();
        ta.pre  = 20;
        ta.rung = 1'b1;
        step();
        for (int i = 0; i < 7; i++) tick_a();
        chk("t6_acc7", ta.acc, 7);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_acc", ta.acc, 0);
        chk("t6_rst_tt", {31'b0, ta.tt}, 0);
        chk("t6_rst_en", {31'b0, ta.en}, 0);
        chk("t6_rst_dn", {31'b0, ta.dn}, 0);
        step();
        rst = 1'b0;
        step();
        tick_a();
        tick_a();
        chk("t6_acc2", ta.acc, 2);
        ta.res  = 1'b1;
        ta.tick = 1'b1;
        step();
        ta.res  = 1'b0;
        ta.tick = 1'b0;
        chk("t6_res_acc", ta.acc, 0);
        chk("t6_res_tt", {31'b0, ta.tt}, 1);
        step();
        chk("t6_res_hold", ta.acc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
